// File: rtl/axil_cfg_router.sv
// AXI-Lite slave that decodes a 4 KiB-windowed configuration space and forwards
// one transaction at a time to a simple request/response downstream port.
module axil_cfg_router #(
  parameter logic [31:0] BASE_ADDR = 32'h6000_0000,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic        axi_clk,
  input  logic        axi_reset,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        req_valid,
  input  logic        req_ready,
  output logic        req_we,
  output logic [3:0]  req_sel,
  output logic [11:0] req_addr,
  output logic [31:0] req_wdata,
  output logic [3:0]  req_wstrb,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_rdata,
  input  logic        rsp_err,
  output logic        busy
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  logic [1:0]    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          prefer_wr_q, prefer_wr_d;
  logic          awready_q, awready_d, wready_q, wready_d, arready_q, arready_d;
  logic          bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [1:0]    bresp_q, bresp_d, rresp_q, rresp_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          req_valid_q, req_valid_d, req_we_q, req_we_d;
  logic [3:0]    req_sel_q, req_sel_d, req_wstrb_q, req_wstrb_d;
  logic [11:0]   req_addr_q, req_addr_d;
  logic [31:0]   req_wdata_q, req_wdata_d;
  logic          busy_q, busy_d;

  logic [31:0]   acc_addr;
  logic          acc_hit, wr_elig, rd_elig, grant_wr, grant_rd;
  logic [TW-1:0] timer_inc;

  // Ready pulses are registered: the cycle they are high is the acceptance cycle.
  assign acc_addr  = awready_q ? awaddr : araddr;
  assign acc_hit   = (acc_addr[31:16] == BASE_ADDR[31:16]) && (acc_addr[15:12] <= 4'd8);
  assign wr_elig   = awvalid && wvalid;
  assign rd_elig   = arvalid;
  assign grant_wr  = wr_elig && (!rd_elig || prefer_wr_q);
  assign grant_rd  = rd_elig && !grant_wr;
  assign timer_inc = timer_q + TW'(1);

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    prefer_wr_d = prefer_wr_q;
    awready_d   = 1'b0;
    wready_d    = 1'b0;
    arready_d   = 1'b0;
    bvalid_d    = bvalid_q;
    rvalid_d    = rvalid_q;
    bresp_d     = bresp_q;
    rresp_d     = rresp_q;
    rdata_d     = rdata_q;
    req_valid_d = req_valid_q;
    req_we_d    = req_we_q;
    req_sel_d   = req_sel_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    req_wstrb_d = req_wstrb_q;

    case (state_q)
      S_IDLE: begin
        if (awready_q || arready_q) begin
          req_we_d    = awready_q;
          req_sel_d   = acc_addr[15:12];
          req_addr_d  = acc_addr[11:0];
          req_wdata_d = awready_q ? wdata : 32'd0;
          req_wstrb_d = awready_q ? wstrb : 4'd0;
          if (acc_hit) begin
            req_valid_d = 1'b1;
            state_d     = S_REQ;
          end else begin
            // Decode miss is answered locally, never reaching downstream.
            state_d = S_RESP;
            if (awready_q) begin
              bvalid_d = 1'b1;
              bresp_d  = RESP_DECERR;
            end else begin
              rvalid_d = 1'b1;
              rresp_d  = RESP_DECERR;
              rdata_d  = 32'd0;
            end
          end
        end else if (grant_wr) begin
          awready_d   = 1'b1;
          wready_d    = 1'b1;
          prefer_wr_d = 1'b0;
        end else if (grant_rd) begin
          arready_d   = 1'b1;
          prefer_wr_d = 1'b1;
        end
      end
      S_REQ: begin
        if (req_ready) begin
          req_valid_d = 1'b0;
          timer_d     = '0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (rsp_valid) begin
          state_d = S_RESP;
          if (req_we_q) begin
            bvalid_d = 1'b1;
            bresp_d  = rsp_err ? RESP_SLVERR : RESP_OKAY;
          end else begin
            rvalid_d = 1'b1;
            rresp_d  = rsp_err ? RESP_SLVERR : RESP_OKAY;
            rdata_d  = rsp_err ? 32'd0 : rsp_rdata;
          end
        end else begin
          timer_d = timer_inc;
          if (timer_inc == TW'(TIMEOUT)) begin
            state_d = S_RESP;
            if (req_we_q) begin
              bvalid_d = 1'b1;
              bresp_d  = RESP_SLVERR;
            end else begin
              rvalid_d = 1'b1;
              rresp_d  = RESP_SLVERR;
              rdata_d  = 32'd0;
            end
          end
        end
      end
      default: begin
        if ((bvalid_q && bready) || (rvalid_q && rready)) begin
          bvalid_d = 1'b0;
          rvalid_d = 1'b0;
          bresp_d  = RESP_OKAY;
          rresp_d  = RESP_OKAY;
          rdata_d  = 32'd0;
          state_d  = S_IDLE;
        end
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      state_q     <= S_IDLE;
      timer_q     <= '0;
      prefer_wr_q <= 1'b1;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      arready_q   <= 1'b0;
      bvalid_q    <= 1'b0;
      rvalid_q    <= 1'b0;
      bresp_q     <= 2'b00;
      rresp_q     <= 2'b00;
      rdata_q     <= 32'd0;
      req_valid_q <= 1'b0;
      req_we_q    <= 1'b0;
      req_sel_q   <= 4'd0;
      req_addr_q  <= 12'd0;
      req_wdata_q <= 32'd0;
      req_wstrb_q <= 4'd0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      prefer_wr_q <= prefer_wr_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      arready_q   <= arready_d;
      bvalid_q    <= bvalid_d;
      rvalid_q    <= rvalid_d;
      bresp_q     <= bresp_d;
      rresp_q     <= rresp_d;
      rdata_q     <= rdata_d;
      req_valid_q <= req_valid_d;
      req_we_q    <= req_we_d;
      req_sel_q   <= req_sel_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      req_wstrb_q <= req_wstrb_d;
      busy_q      <= busy_d;
    end
  end

  assign awready   = awready_q;
  assign wready    = wready_q;
  assign arready   = arready_q;
  assign bvalid    = bvalid_q;
  assign rvalid    = rvalid_q;
  assign bresp     = bresp_q;
  assign rresp     = rresp_q;
  assign rdata     = rdata_q;
  assign req_valid = req_valid_q;
  assign req_we    = req_we_q;
  assign req_sel   = req_sel_q;
  assign req_addr  = req_addr_q;
  assign req_wdata = req_wdata_q;
  assign req_wstrb = req_wstrb_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_axil_cfg_router.sv
// Directed bench for axil_cfg_router with a small downstream responder model.
module tb_axil_cfg_router;

  localparam int unsigned TIMEOUT = 1023;

  logic        axi_clk = 1'b0, axi_reset = 1'b1;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic        req_valid, req_we, busy;
  logic        req_ready = 1'b1;
  logic [3:0]  req_sel, req_wstrb;
  logic [11:0] req_addr;
  logic [31:0] req_wdata;
  wire         rsp_valid;
  logic        rsp_auto = 1'b0, force_rsp = 1'b0, rsp_en = 1'b1, rsp_err_cfg = 1'b0;
  logic [31:0] rsp_rdata = '0;
  logic        rsp_err = 1'b0;

  assign rsp_valid = rsp_auto | force_rsp;

  always #5 axi_clk = ~axi_clk;

  axil_cfg_router #(.BASE_ADDR(32'h6000_0000), .TIMEOUT(TIMEOUT)) dut (
    .axi_clk(axi_clk), .axi_reset(axi_reset),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_sel(req_sel),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
  );

  int n_tests = 0, n_fail = 0;

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Downstream model: answers one cycle after the request handshake, on the falling edge.
  logic [31:0] mem [16];
  logic        pending = 1'b0, last_we = 1'b0;
  logic [3:0]  last_sel = '0, last_wstrb = '0;
  logic [11:0] last_addr = '0;
  logic [31:0] last_wdata = '0;
  int          req_cnt = 0;

  initial begin
    forever begin
      @(negedge axi_clk);
      rsp_auto  = pending && rsp_en;
      rsp_err   = rsp_err_cfg;
      rsp_rdata = mem[last_sel];
      pending   = req_valid && req_ready;
      if (pending) begin
        req_cnt++;
        last_we = req_we; last_sel = req_sel; last_addr = req_addr;
        last_wdata = req_wdata; last_wstrb = req_wstrb;
        if (req_we) mem[req_sel] = req_wdata;
      end
    end
  end

  task automatic do_read(input logic [31:0] a, input int stall, output logic [31:0] d,
                         output logic [1:0] r, output int lat, output bit got_req);
    bit ok;
    int c0;
    @(posedge axi_clk); #1;
    arvalid = 1'b1; araddr = a; rready = (stall == 0);
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge axi_clk); #1;
      if (arready) begin ok = 1; break; end
    end
    check("rd_arready_seen", 128'(ok), 128'(1));
    c0 = req_cnt; ok = 0; lat = 0; d = '0; r = '0;
    for (int k = 1; k < int'(TIMEOUT) + 50; k++) begin
      @(posedge axi_clk); #1;
      if (k == 1) arvalid = 1'b0;
      if (arready) begin ok = 0; break; end
      if (rvalid) begin ok = 1; lat = k; d = rdata; r = rresp; break; end
    end
    arvalid = 1'b0;
    check("rd_rvalid_seen", 128'(ok), 128'(1));
    got_req = (req_cnt != c0);
    for (int s = 0; s < stall; s++) begin
      @(posedge axi_clk); #1;
      check("rd_stall_rvalid", 128'(rvalid), 128'(1));
      check("rd_stall_rdata", 128'(rdata), 128'(d));
    end
    rready = 1'b1;
    @(posedge axi_clk); #1;
    rready = 1'b0;
    check("rd_done_rvalid", 128'(rvalid), 128'(0));
    check("rd_done_rresp", 128'(rresp), 128'(0));
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] dat, input logic [3:0] st,
                          output logic [1:0] r, output int lat);
    bit ok;
    @(posedge axi_clk); #1;
    awvalid = 1'b1; wvalid = 1'b1; awaddr = a; wdata = dat; wstrb = st; bready = 1'b1;
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge axi_clk); #1;
      if (awready) begin ok = 1; break; end
    end
    check("wr_awready_seen", 128'(ok), 128'(1));
    check("wr_wready_with_aw", 128'(wready), 128'(1));
    ok = 0; lat = 0; r = '0;
    for (int k = 1; k < int'(TIMEOUT) + 50; k++) begin
      @(posedge axi_clk); #1;
      if (k == 1) begin awvalid = 1'b0; wvalid = 1'b0; end
      if (bvalid) begin ok = 1; lat = k; r = bresp; break; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    check("wr_bvalid_seen", 128'(ok), 128'(1));
    @(posedge axi_clk); #1;
    bready = 1'b0;
    check("wr_done_bvalid", 128'(bvalid), 128'(0));
    check("wr_done_bresp", 128'(bresp), 128'(0));
  endtask

  function automatic logic [127:0] all_outs();
    return 128'({awready, wready, arready, bvalid, rvalid, req_valid, req_we, busy,
                 bresp, rresp, rdata, req_sel, req_addr, req_wdata, req_wstrb});
  endfunction

  logic [31:0] d;
  logic [1:0]  r;
  int          lat;
  bit          got;
  bit          ok;
  logic [3:0]  gseq;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 32'hC0DE_0000 + 32'(i);
    mem[5] = 32'h0000_001F;

    // Reset state and no ready before the first edge after release.
    #22;
    check("reset_outputs", all_outs(), 128'(0));
    arvalid = 1'b1; araddr = 32'h6000_5000;
    #1 axi_reset = 1'b0;
    #1 check("no_ready_at_release", 128'(arready), 128'(0));
    arvalid = 1'b0;
    @(posedge axi_clk); #1;

    do_read(32'h6000_5000, 0, d, r, lat, got);
    check("rd5_rdata", 128'(d), 128'(32'h1F));
    check("rd5_rresp", 128'(r), 128'(0));
    check("rd5_latency", 128'(lat), 128'(3));
    check("rd5_sel", 128'(last_sel), 128'(5));
    check("rd5_addr", 128'(last_addr), 128'(0));
    check("rd5_we", 128'(last_we), 128'(0));

    do_write(32'h6000_7000, 32'd3, 4'hF, r, lat);
    check("wr7_we", 128'(last_we), 128'(1));
    check("wr7_sel", 128'(last_sel), 128'(7));
    check("wr7_wdata", 128'(last_wdata), 128'(3));
    check("wr7_wstrb", 128'(last_wstrb), 128'(4'hF));
    check("wr7_bresp", 128'(r), 128'(0));
    check("wr7_latency", 128'(lat), 128'(3));
    do_read(32'h6000_7000, 0, d, r, lat, got);
    check("rd7_rdata", 128'(d), 128'(3));

    // Decode misses: window above 8 and wrong base.
    do_read(32'h6000_9000, 0, d, r, lat, got);
    check("rd9_no_req", 128'(got), 128'(0));
    check("rd9_rresp", 128'(r), 128'(2'b11));
    check("rd9_rdata", 128'(d), 128'(0));
    check("rd9_latency", 128'(lat), 128'(1));
    do_read(32'h7000_0000, 0, d, r, lat, got);
    check("rdbase_no_req", 128'(got), 128'(0));
    check("rdbase_rresp", 128'(r), 128'(2'b11));
    check("rdbase_latency", 128'(lat), 128'(1));
    do_write(32'h6000_A000, 32'h55, 4'hF, r, lat);
    check("wrmiss_bresp", 128'(r), 128'(2'b11));
    check("wrmiss_latency", 128'(lat), 128'(1));

    // Downstream error on the mailbox window.
    rsp_err_cfg = 1'b1;
    do_read(32'h6000_2100, 0, d, r, lat, got);
    check("rderr_rresp", 128'(r), 128'(2'b10));
    check("rderr_rdata", 128'(d), 128'(0));
    check("rderr_addr", 128'(last_addr), 128'(12'h100));
    do_write(32'h6000_2100, 32'h77, 4'h3, r, lat);
    check("wrerr_bresp", 128'(r), 128'(2'b10));
    rsp_err_cfg = 1'b0;

    // Timeout, then a late response that must be ignored.
    rsp_en = 1'b0;
    do_read(32'h6000_8000, 0, d, r, lat, got);
    check("to_latency", 128'(lat), 128'(TIMEOUT + 2));
    check("to_rresp", 128'(r), 128'(2'b10));
    check("to_rdata", 128'(d), 128'(0));
    rsp_en = 1'b1;
    repeat (4) @(posedge axi_clk);
    #1 force_rsp = 1'b1;
    @(posedge axi_clk); #1 force_rsp = 1'b0;
    ok = 1;
    repeat (3) begin
      @(posedge axi_clk); #1;
      if (busy || rvalid || bvalid || req_valid) ok = 0;
    end
    check("late_rsp_ignored", 128'(ok), 128'(1));
    do_read(32'h6000_5000, 0, d, r, lat, got);
    check("after_to_rdata", 128'(d), 128'(32'h1F));
    check("after_to_latency", 128'(lat), 128'(3));

    // Fresh reset so the first tie goes to the write; then four back-to-back ties.
    @(posedge axi_clk); #2 axi_reset = 1'b1;
    @(posedge axi_clk); #2 axi_reset = 1'b0;
    @(posedge axi_clk); #1;
    bready = 1'b1; rready = 1'b1;
    awaddr = 32'h6000_1000; wdata = 32'hA5; wstrb = 4'hF; araddr = 32'h6000_3000;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    gseq = '0;
    for (int g = 0; g < 4; g++) begin
      ok = 0;
      for (int k = 0; k < 50; k++) begin
        @(posedge axi_clk); #1;
        if (awready || arready) begin ok = 1; break; end
      end
      check("arb_grant_seen", 128'(ok), 128'(1));
      check("arb_one_grant", 128'(awready && arready), 128'(0));
      gseq[3-g] = awready;
      if (g == 3) begin
        @(posedge axi_clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      end
    end
    check("arb_sequence_WRWR", 128'(gseq), 128'(4'b1010));
    ok = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge axi_clk); #1;
      if (!busy) begin ok = 1; break; end
    end
    check("arb_drained", 128'(ok), 128'(1));
    bready = 1'b0; rready = 1'b0;

    do_read(32'h6000_5000, 3, d, r, lat, got);
    check("stall_rdata", 128'(d), 128'(32'h1F));

    // Asynchronous reset while waiting on downstream.
    rsp_en = 1'b0;
    @(posedge axi_clk); #1;
    arvalid = 1'b1; araddr = 32'h6000_8000;
    ok = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge axi_clk); #1;
      if (arready) begin ok = 1; break; end
    end
    check("rst_arready_seen", 128'(ok), 128'(1));
    @(posedge axi_clk); #1 arvalid = 1'b0;
    @(posedge axi_clk); @(posedge axi_clk);
    #1 check("rst_busy_before", 128'(busy), 128'(1));
    #2 axi_reset = 1'b1;
    #1 check("rst_async_outputs", all_outs(), 128'(0));
    @(posedge axi_clk); #2 axi_reset = 1'b0;
    rsp_en = 1'b1;
    do_read(32'h6000_4000, 0, d, r, lat, got);
    check("post_rst_rdata", 128'(d), 128'(32'hC0DE_0004));
    check("post_rst_rresp", 128'(r), 128'(0));
    check("post_rst_latency", 128'(lat), 128'(3));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
